// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: op, size and trap codes plus FSM state type for the memory access controller
package mem_ctrl_pkg;
    localparam logic [2:0] OP_LD     = 3'b000;
    localparam logic [2:0] OP_ST     = 3'b001;
    localparam logic [2:0] OP_LDD    = 3'b010;
    localparam logic [2:0] OP_STD    = 3'b011;
    localparam logic [2:0] OP_LDSTUB = 3'b100;
    localparam logic [2:0] OP_SWAP   = 3'b101;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] TRAP_NONE     = 2'b00;
    localparam logic [1:0] TRAP_MISALIGN = 2'b01;
    localparam logic [1:0] TRAP_ILLEGAL  = 2'b10;
    typedef enum logic [2:0] {S_IDLE, S_ACC1, S_ACC2, S_RMW_WR, S_RESP} state_t;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: pipeline request/response and data-memory control bundle
interface mem_access_ctrl_if #(parameter int ADDR_W = 9, parameter int DATA_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [1:0]        req_size;
    logic              req_sext;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata_hi;
    logic [DATA_W-1:0] req_wdata_lo;
    logic              resp_valid;
    logic [1:0]        resp_trap;
    logic [DATA_W-1:0] resp_rdata_hi;
    logic [DATA_W-1:0] resp_rdata_lo;
    logic              mem_enable;
    logic              mem_rw;
    logic [1:0]        mem_size;
    logic              mem_sext;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    modport master (
        output req_valid, req_op, req_size, req_sext, req_addr, req_wdata_hi, req_wdata_lo, mem_rdata,
        input  req_ready, resp_valid, resp_trap, resp_rdata_hi, resp_rdata_lo,
               mem_enable, mem_rw, mem_size, mem_sext, mem_addr, mem_wdata
    );
    modport slave (
        input  req_valid, req_op, req_size, req_sext, req_addr, req_wdata_hi, req_wdata_lo, mem_rdata,
        output req_ready, resp_valid, resp_trap, resp_rdata_hi, resp_rdata_lo,
               mem_enable, mem_rw, mem_size, mem_sext, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_align_check.sv
// mem_align_check: flags illegal op codes and misaligned addresses for a request
module mem_align_check
    import mem_ctrl_pkg::*;
(
    input  logic [2:0] op,
    input  logic [1:0] size,
    input  logic [2:0] addr,
    output logic       misaligned,
    output logic       illegal
);
    assign illegal = op[2] & op[1];
    assign misaligned = (op == OP_LD || op == OP_ST) ? (size == SZ_BYTE ? 1'b0 : size == SZ_HALF ? addr[0] : |addr[1:0]) :
                        (op == OP_LDD || op == OP_STD) ? |addr :
                        (op == OP_SWAP) ? |addr[1:0] : 1'b0;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences single, double and read-modify-write accesses to the byte memory
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input logic clk,
    input logic reset,
    mem_access_ctrl_if.slave bus
);
    state_t            state;
    logic [2:0]        op_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] rd_q;
    logic              ready;
    logic              misaligned;
    logic              illegal;
    logic              acc1;
    logic              acc2;
    logic              rmw;

    mem_align_check u_align (
        .op         (bus.req_op),
        .size       (bus.req_size),
        .addr       (bus.req_addr[2:0]),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    assign acc1 = state == S_ACC1;
    assign acc2 = state == S_ACC2;
    assign rmw  = state == S_RMW_WR;
    assign bus.req_ready  = ready;
    assign bus.mem_enable = acc1 | acc2 | rmw;
    assign bus.mem_rw     = acc1 ? (op_q == OP_ST || op_q == OP_STD) : ((acc2 && op_q == OP_STD) || rmw);
    assign bus.mem_size   = acc1 ? ((op_q == OP_LD || op_q == OP_ST) ? size_q : op_q == OP_LDSTUB ? SZ_BYTE : SZ_WORD) :
                            acc2 ? SZ_WORD : rmw ? (op_q == OP_LDSTUB ? SZ_BYTE : SZ_WORD) : 2'b00;
    assign bus.mem_sext   = acc1 && op_q == OP_LD && sext_q;
    assign bus.mem_addr   = acc2 ? addr_q + ADDR_W'(4) : (acc1 || rmw) ? addr_q : '0;
    assign bus.mem_wdata  = acc1 ? (op_q == OP_ST ? lo_q : op_q == OP_STD ? hi_q : '0) :
                            acc2 ? (op_q == OP_STD ? lo_q : '0) :
                            rmw ? (op_q == OP_LDSTUB ? DATA_W'(8'hFF) : lo_q) : '0;

    // Request capture, access sequencing and registered response generation
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_IDLE;
            ready             <= 1'b1;
            op_q              <= '0;
            size_q            <= '0;
            sext_q            <= 1'b0;
            addr_q            <= '0;
            hi_q              <= '0;
            lo_q              <= '0;
            rd_q              <= '0;
            bus.resp_valid    <= 1'b0;
            bus.resp_trap     <= TRAP_NONE;
            bus.resp_rdata_hi <= '0;
            bus.resp_rdata_lo <= '0;
        end else begin
            bus.resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        ready  <= 1'b0;
                        op_q   <= bus.req_op;
                        size_q <= bus.req_size == 2'b11 ? SZ_WORD : bus.req_size;
                        sext_q <= bus.req_sext;
                        addr_q <= bus.req_addr;
                        hi_q   <= bus.req_wdata_hi;
                        lo_q   <= bus.req_wdata_lo;
                        if (illegal || misaligned) begin
                            state             <= S_RESP;
                            bus.resp_valid    <= 1'b1;
                            bus.resp_trap     <= illegal ? TRAP_ILLEGAL : TRAP_MISALIGN;
                            bus.resp_rdata_hi <= '0;
                            bus.resp_rdata_lo <= '0;
                        end else begin
                            state <= S_ACC1;
                        end
                    end
                end
                S_ACC1: begin
                    rd_q <= bus.mem_rdata;
                    if (op_q == OP_LDD || op_q == OP_STD) begin
                        state <= S_ACC2;
                    end else if (op_q == OP_LDSTUB || op_q == OP_SWAP) begin
                        state <= S_RMW_WR;
                    end else begin
                        state             <= S_RESP;
                        bus.resp_valid    <= 1'b1;
                        bus.resp_trap     <= TRAP_NONE;
                        bus.resp_rdata_hi <= '0;
                        bus.resp_rdata_lo <= op_q == OP_LD ? bus.mem_rdata : '0;
                    end
                end
                S_ACC2: begin
                    state             <= S_RESP;
                    bus.resp_valid    <= 1'b1;
                    bus.resp_trap     <= TRAP_NONE;
                    bus.resp_rdata_hi <= op_q == OP_LDD ? rd_q : '0;
                    bus.resp_rdata_lo <= op_q == OP_LDD ? bus.mem_rdata : '0;
                end
                S_RMW_WR: begin
                    state             <= S_RESP;
                    bus.resp_valid    <= 1'b1;
                    bus.resp_trap     <= TRAP_NONE;
                    bus.resp_rdata_hi <= '0;
                    bus.resp_rdata_lo <= rd_q;
                end
                S_RESP: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of the memory access controller against a big-endian byte memory model
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    int en_cnt = 0;
    logic [7:0] m [512];
    logic [8:0] a0, a1, a2, a3;

    mem_access_ctrl_if bus ();
    mem_access_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Combinational read port of the 512x8 memory
    always_comb begin
        a0 = bus.mem_addr;
        a1 = a0 + 9'd1;
        a2 = a0 + 9'd2;
        a3 = a0 + 9'd3;
        bus.mem_rdata = bus.mem_size == 2'b00 ? (bus.mem_sext ? {{24{m[a0][7]}}, m[a0]} : {24'h0, m[a0]}) :
                        bus.mem_size == 2'b01 ? (bus.mem_sext ? {{16{m[a0][7]}}, m[a0], m[a1]} : {16'h0, m[a0], m[a1]}) :
                        {m[a0], m[a1], m[a2], m[a3]};
    end

    // Synchronous write port and enable-cycle counter
    always @(posedge clk) begin
        if (bus.mem_enable) en_cnt <= en_cnt + 1;
        if (bus.mem_enable && bus.mem_rw) begin
            if (bus.mem_size == 2'b00) m[a0] <= bus.mem_wdata[7:0];
            else if (bus.mem_size == 2'b01) begin
                m[a0] <= bus.mem_wdata[15:8];
                m[a1] <= bus.mem_wdata[7:0];
            end else begin
                m[a0] <= bus.mem_wdata[31:24];
                m[a1] <= bus.mem_wdata[23:16];
                m[a2] <= bus.mem_wdata[15:8];
                m[a3] <= bus.mem_wdata[7:0];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request and returns in cycle N+1 after the accept edge
    task automatic issue(input logic [2:0] op, input logic [1:0] size, input logic sext, input logic [8:0] addr,
                         input logic [31:0] hi, input logic [31:0] lo);
        for (int k = 0; k < 10 && !bus.req_ready; k++) step();
        bus.req_op = op;
        bus.req_size = size;
        bus.req_sext = sext;
        bus.req_addr = addr;
        bus.req_wdata_hi = hi;
        bus.req_wdata_lo = lo;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
    endtask

    // Advances until resp_valid; lat is cycles after the accept edge, -1 on timeout
    task automatic wait_resp(input int start, output int lat);
        lat = start;
        while (!bus.resp_valid && lat < 12) begin
            step();
            lat++;
        end
        if (!bus.resp_valid) lat = -1;
    endtask

    task automatic test_reset();
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
        checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
        checks++; if (bus.resp_trap !== 2'b00) begin failures++; $display("FAIL reset_trap got=%b exp=00", bus.resp_trap); end
        checks++; if ({bus.resp_rdata_hi, bus.resp_rdata_lo} !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h_%h exp=0", bus.resp_rdata_hi, bus.resp_rdata_lo); end
        checks++; if ({bus.mem_enable, bus.mem_rw, bus.mem_size, bus.mem_sext, bus.mem_addr, bus.mem_wdata} !== 46'h0) begin failures++; $display("FAIL reset_mem got=%b%b%b%b %h %h exp=0", bus.mem_enable, bus.mem_rw, bus.mem_size, bus.mem_sext, bus.mem_addr, bus.mem_wdata); end
    endtask

    task automatic test_ld_st();
        int lat;
        issue(3'b001, 2'b10, 1'b0, 9'd8, 32'h0, 32'hDEADBEEF);
        checks++; if ({bus.mem_enable, bus.mem_rw, bus.mem_size, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 2'b10, 9'd8, 32'hDEADBEEF}) begin failures++; $display("FAIL st_access got en=%b rw=%b sz=%b a=%0d d=%h exp 1 1 10 8 deadbeef", bus.mem_enable, bus.mem_rw, bus.mem_size, bus.mem_addr, bus.mem_wdata); end
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL st_busy_ready got=%b exp=0", bus.req_ready); end
        wait_resp(1, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL st_latency got=%0d exp=2", lat); end
        checks++; if ({bus.resp_trap, bus.resp_rdata_lo} !== {2'b00, 32'h0}) begin failures++; $display("FAIL st_resp got trap=%b lo=%h exp 00 0", bus.resp_trap, bus.resp_rdata_lo); end
        issue(3'b000, 2'b10, 1'b0, 9'd8, 32'h0, 32'h0);
        checks++; if ({bus.mem_rw, bus.mem_addr} !== {1'b0, 9'd8}) begin failures++; $display("FAIL ld_access got rw=%b a=%0d exp 0 8", bus.mem_rw, bus.mem_addr); end
        wait_resp(1, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL ld_latency got=%0d exp=2", lat); end
        checks++; if ({bus.resp_trap, bus.resp_rdata_lo} !== {2'b00, 32'hDEADBEEF}) begin failures++; $display("FAIL ld_word got trap=%b lo=%h exp 00 deadbeef", bus.resp_trap, bus.resp_rdata_lo); end
        step();
        checks++; if ({bus.resp_valid, bus.req_ready, bus.resp_rdata_lo} !== {1'b0, 1'b1, 32'hDEADBEEF}) begin failures++; $display("FAIL ld_hold got v=%b rdy=%b lo=%h exp 0 1 deadbeef", bus.resp_valid, bus.req_ready, bus.resp_rdata_lo); end
        issue(3'b000, 2'b00, 1'b1, 9'd8, 32'h0, 32'h0);
        wait_resp(1, lat);
        checks++; if (bus.resp_rdata_lo !== 32'hFFFFFFDE) begin failures++; $display("FAIL ld_byte_sext got=%h exp=ffffffde", bus.resp_rdata_lo); end
        issue(3'b000, 2'b01, 1'b0, 9'd10, 32'h0, 32'h0);
        wait_resp(1, lat);
        checks++; if (bus.resp_rdata_lo !== 32'h0000BEEF) begin failures++; $display("FAIL ld_half got=%h exp=0000beef", bus.resp_rdata_lo); end
        issue(3'b000, 2'b01, 1'b1, 9'd10, 32'h0, 32'h0);
        wait_resp(1, lat);
        checks++; if (bus.resp_rdata_lo !== 32'hFFFFBEEF) begin failures++; $display("FAIL ld_half_sext got=%h exp=ffffbeef", bus.resp_rdata_lo); end
    endtask

    task automatic test_double();
        int lat;
        issue(3'b011, 2'b00, 1'b0, 9'd16, 32'h11112222, 32'h33334444);
        checks++; if ({bus.mem_rw, bus.mem_size, bus.mem_addr, bus.mem_wdata} !== {1'b1, 2'b10, 9'd16, 32'h11112222}) begin failures++; $display("FAIL std_acc1 got rw=%b sz=%b a=%0d d=%h exp 1 10 16 11112222", bus.mem_rw, bus.mem_size, bus.mem_addr, bus.mem_wdata); end
        step();
        checks++; if ({bus.mem_rw, bus.mem_size, bus.mem_addr, bus.mem_wdata} !== {1'b1, 2'b10, 9'd20, 32'h33334444}) begin failures++; $display("FAIL std_acc2 got rw=%b sz=%b a=%0d d=%h exp 1 10 20 33334444", bus.mem_rw, bus.mem_size, bus.mem_addr, bus.mem_wdata); end
        wait_resp(2, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL std_latency got=%0d exp=3", lat); end
        checks++; if ({bus.resp_rdata_hi, bus.resp_rdata_lo} !== 64'h0) begin failures++; $display("FAIL std_rdata got=%h_%h exp=0", bus.resp_rdata_hi, bus.resp_rdata_lo); end
        issue(3'b010, 2'b00, 1'b0, 9'd16, 32'h0, 32'h0);
        checks++; if ({bus.mem_rw, bus.mem_addr} !== {1'b0, 9'd16}) begin failures++; $display("FAIL ldd_acc1 got rw=%b a=%0d exp 0 16", bus.mem_rw, bus.mem_addr); end
        step();
        checks++; if ({bus.mem_rw, bus.mem_addr} !== {1'b0, 9'd20}) begin failures++; $display("FAIL ldd_acc2 got rw=%b a=%0d exp 0 20", bus.mem_rw, bus.mem_addr); end
        wait_resp(2, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL ldd_latency got=%0d exp=3", lat); end
        checks++; if ({bus.resp_rdata_hi, bus.resp_rdata_lo} !== 64'h11112222_33334444) begin failures++; $display("FAIL ldd_rdata got=%h_%h exp=11112222_33334444", bus.resp_rdata_hi, bus.resp_rdata_lo); end
    endtask

    task automatic test_traps();
        int lat;
        int e0;
        e0 = en_cnt;
        issue(3'b000, 2'b01, 1'b0, 9'd3, 32'h0, 32'h0);
        wait_resp(1, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL trap_half_latency got=%0d exp=1", lat); end
        checks++; if ({bus.resp_trap, bus.resp_rdata_hi, bus.resp_rdata_lo} !== {2'b01, 64'h0}) begin failures++; $display("FAIL trap_half got trap=%b d=%h_%h exp 01 0", bus.resp_trap, bus.resp_rdata_hi, bus.resp_rdata_lo); end
        issue(3'b010, 2'b00, 1'b0, 9'd12, 32'h0, 32'h0);
        wait_resp(1, lat);
        checks++; if ({lat, bus.resp_trap} !== {32'd1, 2'b01}) begin failures++; $display("FAIL trap_ldd got lat=%0d trap=%b exp 1 01", lat, bus.resp_trap); end
        issue(3'b101, 2'b00, 1'b0, 9'd2, 32'h0, 32'h0);
        wait_resp(1, lat);
        checks++; if ({lat, bus.resp_trap} !== {32'd1, 2'b01}) begin failures++; $display("FAIL trap_swap got lat=%0d trap=%b exp 1 01", lat, bus.resp_trap); end
        issue(3'b111, 2'b10, 1'b0, 9'd0, 32'h0, 32'h0);
        wait_resp(1, lat);
        checks++; if ({lat, bus.resp_trap} !== {32'd1, 2'b10}) begin failures++; $display("FAIL trap_illegal got lat=%0d trap=%b exp 1 10", lat, bus.resp_trap); end
        issue(3'b110, 2'b01, 1'b0, 9'd1, 32'h0, 32'h0);
        wait_resp(1, lat);
        checks++; if (bus.resp_trap !== 2'b10) begin failures++; $display("FAIL trap_priority got=%b exp=10", bus.resp_trap); end
        step();
        checks++; if (en_cnt !== e0) begin failures++; $display("FAIL trap_no_enable got=%0d exp=%0d", en_cnt, e0); end
    endtask

    task automatic test_ldstub();
        int lat;
        issue(3'b001, 2'b00, 1'b0, 9'd40, 32'h0, 32'h00000005);
        wait_resp(1, lat);
        issue(3'b100, 2'b10, 1'b1, 9'd40, 32'h0, 32'h0);
        checks++; if ({bus.mem_rw, bus.mem_size, bus.mem_sext, bus.mem_addr} !== {1'b0, 2'b00, 1'b0, 9'd40}) begin failures++; $display("FAIL ldstub_rd got rw=%b sz=%b sx=%b a=%0d exp 0 00 0 40", bus.mem_rw, bus.mem_size, bus.mem_sext, bus.mem_addr); end
        step();
        checks++; if ({bus.mem_rw, bus.mem_size, bus.mem_addr, bus.mem_wdata[7:0]} !== {1'b1, 2'b00, 9'd40, 8'hFF}) begin failures++; $display("FAIL ldstub_wr got rw=%b sz=%b a=%0d d=%h exp 1 00 40 ff", bus.mem_rw, bus.mem_size, bus.mem_addr, bus.mem_wdata); end
        wait_resp(2, lat);
        checks++; if ({lat, bus.resp_rdata_hi, bus.resp_rdata_lo} !== {32'd3, 64'h00000000_00000005}) begin failures++; $display("FAIL ldstub_resp got lat=%0d d=%h_%h exp 3 0_5", lat, bus.resp_rdata_hi, bus.resp_rdata_lo); end
        issue(3'b000, 2'b00, 1'b0, 9'd40, 32'h0, 32'h0);
        wait_resp(1, lat);
        checks++; if (bus.resp_rdata_lo !== 32'h000000FF) begin failures++; $display("FAIL ldstub_after got=%h exp=000000ff", bus.resp_rdata_lo); end
    endtask

    task automatic test_swap();
        int lat;
        issue(3'b001, 2'b11, 1'b0, 9'd504, 32'h0, 32'h01020304);
        wait_resp(1, lat);
        issue(3'b101, 2'b00, 1'b0, 9'd504, 32'h0, 32'hCAFEF00D);
        wait_resp(1, lat);
        checks++; if ({lat, bus.resp_rdata_lo} !== {32'd3, 32'h01020304}) begin failures++; $display("FAIL swap_resp got lat=%0d lo=%h exp 3 01020304", lat, bus.resp_rdata_lo); end
        issue(3'b000, 2'b10, 1'b0, 9'd504, 32'h0, 32'h0);
        wait_resp(1, lat);
        checks++; if (bus.resp_rdata_lo !== 32'hCAFEF00D) begin failures++; $display("FAIL swap_after got=%h exp=cafef00d", bus.resp_rdata_lo); end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit seen;
        issue(3'b001, 2'b10, 1'b0, 9'd496, 32'h0, 32'h55667788);
        wait_resp(1, lat);
        issue(3'b101, 2'b10, 1'b0, 9'd496, 32'h0, 32'h99999999);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({bus.req_ready, bus.resp_valid, bus.mem_enable, bus.resp_rdata_lo} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin failures++; $display("FAIL rst_mid got rdy=%b v=%b en=%b lo=%h exp 1 0 0 0", bus.req_ready, bus.resp_valid, bus.mem_enable, bus.resp_rdata_lo); end
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            seen |= bus.resp_valid | bus.mem_enable;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_quiet got=%b exp=0", seen); end
        issue(3'b000, 2'b10, 1'b0, 9'd496, 32'h0, 32'h0);
        wait_resp(1, lat);
        checks++; if (bus.resp_rdata_lo !== 32'h55667788) begin failures++; $display("FAIL rst_mid_mem got=%h exp=55667788", bus.resp_rdata_lo); end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op = 3'b000;
        bus.req_size = 2'b00;
        bus.req_sext = 1'b0;
        bus.req_addr = 9'd0;
        bus.req_wdata_hi = 32'h0;
        bus.req_wdata_lo = 32'h0;
        step();
        step();
        reset = 1'b0;
        step();
        test_reset();
        test_ld_st();
        test_double();
        test_traps();
        test_ldstub();
        test_swap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
